out_display_bank: RTL and testbench
===================================

# out_display_bank

Parametrised multi-channel signed decimal display driver. It sits after the datapath output stage. On an `out` strobe it captures one of three 16-bit-class sources and takes the two's-complement magnitude. It converts the magnitude to BCD with an iterative shift-add-3 (double-dabble) engine, then latches the active-low 7-segment patterns and the sign into the selected channel. Channels hold their value until rewritten, cleared or reset.

## Interface
- `DATA_W`, 16: source operand width, ≥4.
- `NUM_CH`, 3: number of display channels.
- `DIGITS`, 2: decimal digits shown per channel.
- `CH_W`, 16: width of `display` selector.

- `c`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `out`  in  1  load strobe, sampled only in IDLE.
- `out_data_src`  in  2  01=`mem`, 10=`data_reg`, 11=`mem_reg`, 00=reuse last captured operand.
- `mem`, `data_reg`, `mem_reg`  in  DATA_W each  signed operand sources.
- `display`  in  CH_W  1-based target channel, sampled with `out`.
- `clear`  in  1  synchronous blank of all channels.
- `seg`  out  NUM_CH*DIGITS*7  channel k, digit j (j=0 ones) at bits [(k*DIGITS+j)*7 +: 7], gfedcba, active-low.
- `neg`  out  NUM_CH  per-channel sign lamp, active-high.
- `ovf`  out  NUM_CH  per-channel magnitude overflow flag.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse on write-back edge.

## Operation
- States are IDLE, CONVERT and WRITE.
- IDLE to CONVERT happens on an edge with `out`=1.
  - Load the operand per `out_data_src` and store it as `last_op`.
  - Latch `display` and set `busy`=1.
  - If operand[DATA_W-1]=1, magnitude = ~op+1 and sign=1. Otherwise magnitude = op and sign=0.
  - Magnitude is held unsigned in DATA_W bits, so the most negative value gives 2^(DATA_W-1).
- CONVERT lasts exactly DATA_W edges, one double-dabble step each.
  - BCD register holds ceil(DATA_W*0.302)+1 digits (6 for DATA_W=16).
  - Each step adds 3 to every BCD nibble ≥5, then shifts left one bit, taking in the magnitude MSB.
  - A 5-bit counter terminates the state. The step after the last shift transitions to WRITE.
- WRITE lasts one edge, then returns to IDLE with `busy`=0 and `done`=1 for that cycle.
  - If 1≤display≤NUM_CH, channel display-1 is updated and all other channels are untouched.
  - If display=0 or display>NUM_CH, no channel changes, but `done` still pulses.
  - If any BCD digit at index ≥DIGITS is nonzero: `ovf`=1, all DIGITS digits show dash 7'b0111111, and `neg`=sign.
  - Otherwise: `ovf`=0, digit j shows seg(BCD[j]), and `neg`=sign. Leading zeros are displayed, not blanked.
- Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank is 1111111.
- `out` while `busy`=1 is ignored and not queued.
- `clear`=1 acts on any edge:
  - Every channel goes to seg blank, `neg`=0, `ovf`=0.
  - Any conversion in flight is aborted: return to IDLE, `busy`=0, no `done`.
  - `last_op` is kept.
  - `clear` has priority over a same-edge WRITE or `out`.

## Timing
- Reset values: `seg` all 1, `neg`=0, `ovf`=0, `busy`=0, `done`=0, `last_op`=0, state IDLE.
- Reset takes effect immediately. Mid-conversion reset discards all work.
- Latency: `out` sampled at edge E0, `busy` high after E0, shifts on E1..E_DATA_W.
- Channel outputs and `done` change after E_(DATA_W+1). That is DATA_W+1 cycles, 17 at default.
- Earliest next accepted `out` is at E_(DATA_W+2).
- Outputs are registered with no combinational path from inputs.

## Test plan
- Reset then idle: after `reset` deasserts → `seg` all 1s, `neg`=000, `ovf`=000, `busy`=0 for 20 cycles with `out`=0.
- `data_reg`=0x002A, src=10, display=2, one-cycle `out` → `busy` for 17 cycles, `done` once.
  - Channel 2 (k=1): tens=0011001, ones=0100100, `neg`[1]=0.
  - Channels 1 and 3 stay blank.
- `mem`=0xFFF9, src=01, display=1 → ch1 tens=1000000, ones=1111000, `neg`[0]=1, `ovf`[0]=0.
- `mem_reg`=0x8000, src=11, display=3 → `ovf`[2]=1, both ch3 digits 0111111, `neg`[2]=1.
- Second `out` at cycle 5 of a conversion → ignored, exactly one `done`.
  - `clear` at cycle 8 of the next conversion → all blank, no `done`, `busy`=0 next cycle.
  - `reset` mid-conversion → reset values immediately.
- src=00 after loading 0x0063, display=0 → `done` pulses and no channel changes.
  - Then src=00, display=1 → ch1 shows 9,9 (0010000, 0010000), `neg`=0.

Source files
------------

// File: rtl/out_display_bank_if.sv
// Bus bundle between the datapath output stage and the display bank.
// The master drives the load strobe and operands; the slave returns the display state.
interface out_display_bank_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 3,
    parameter int DIGITS = 2,
    parameter int CH_W   = 16
);
    logic                       out;
    logic [1:0]                 out_data_src;
    logic [DATA_W-1:0]          mem;
    logic [DATA_W-1:0]          data_reg;
    logic [DATA_W-1:0]          mem_reg;
    logic [CH_W-1:0]            display;
    logic                       clear;
    logic [NUM_CH*DIGITS*7-1:0] seg;
    logic [NUM_CH-1:0]          neg;
    logic [NUM_CH-1:0]          ovf;
    logic                       busy;
    logic                       done;

    modport master (
        output out, out_data_src, mem, data_reg, mem_reg, display, clear,
        input  seg, neg, ovf, busy, done
    );

    modport slave (
        input  out, out_data_src, mem, data_reg, mem_reg, display, clear,
        output seg, neg, ovf, busy, done
    );
endinterface

// File: rtl/out_display_bank.sv
// Multi-channel signed decimal display driver: captures an operand, converts its
// magnitude to BCD by double-dabble and latches 7-segment patterns into one channel.
module out_display_bank #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 3,
    parameter int DIGITS = 2,
    parameter int CH_W   = 16
) (
    input  logic              c,
    input  logic              reset,
    out_display_bank_if.slave bus
);
    localparam int BCD_DIGITS = (DATA_W * 302 + 999) / 1000 + 1;
    localparam int BCD_W      = BCD_DIGITS * 4;
    localparam int SEG_W      = NUM_CH * DIGITS * 7;
    localparam int WR_W       = DIGITS * 7;
    localparam logic [4:0] LAST_CNT = 5'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               load_s;
    logic [DATA_W-1:0]  op_s;
    logic [DATA_W-1:0]  mag_in_s;
    logic [DATA_W-1:0]  last_op_r;
    logic [DATA_W-1:0]  mag_r;
    logic [DATA_W-1:0]  mag_step_s;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   bcd_step_s;
    logic [4:0]         cnt_r;
    logic               sign_r;
    logic [CH_W-1:0]    sel_r;
    logic               wr_ovf_s;
    logic [WR_W-1:0]    wr_seg_s;
    logic [SEG_W-1:0]   seg_r;
    logic [NUM_CH-1:0]  neg_r;
    logic [NUM_CH-1:0]  ovf_r;
    logic               busy_r;
    logic               done_r;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            else                     r[i*4 +: 4] = b[i*4 +: 4];
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge c or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_nxt_s;
    end

    // Next-state logic; clear aborts everything and blocks new loads
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        if (bus.clear) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.out) begin
                        state_nxt_s = CONVERT;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CONVERT: begin
                    if (cnt_r == LAST_CNT) state_nxt_s = WRITE;
                    else                   state_nxt_s = CONVERT;
                end
                WRITE:   state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Operand select and two's-complement magnitude (most negative maps to 2^(DATA_W-1))
    always_comb begin
        case (bus.out_data_src)
            2'b01:   op_s = bus.mem;
            2'b10:   op_s = bus.data_reg;
            2'b11:   op_s = bus.mem_reg;
            default: op_s = last_op_r;
        endcase
        if (op_s[DATA_W-1]) mag_in_s = ~op_s + DATA_W'(1);
        else                mag_in_s = op_s;
    end

    // One double-dabble step: adjust nibbles, then shift the magnitude MSB into the BCD LSB
    always_comb begin
        adj_s      = add3(bcd_r);
        bcd_step_s = BCD_W'({adj_s, mag_r[DATA_W-1]});
        mag_step_s = {mag_r[DATA_W-2:0], 1'b0};
    end

    // Write-back pattern: dashes when any digit above the shown range is nonzero
    always_comb begin
        wr_ovf_s = |bcd_r[BCD_W-1:DIGITS*4];
        wr_seg_s = {WR_W{1'b1}};
        for (int j = 0; j < DIGITS; j++) begin
            if (wr_ovf_s) wr_seg_s[j*7 +: 7] = 7'b0111111;
            else          wr_seg_s[j*7 +: 7] = seg7(bcd_r[j*4 +: 4]);
        end
    end

    // Datapath, channel storage and status flags
    always_ff @(posedge c or posedge reset) begin
        if (reset) begin
            last_op_r <= {DATA_W{1'b0}};
            mag_r     <= {DATA_W{1'b0}};
            bcd_r     <= {BCD_W{1'b0}};
            cnt_r     <= 5'd0;
            sign_r    <= 1'b0;
            sel_r     <= {CH_W{1'b0}};
            seg_r     <= {SEG_W{1'b1}};
            neg_r     <= {NUM_CH{1'b0}};
            ovf_r     <= {NUM_CH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            if (bus.clear) begin
                seg_r <= {SEG_W{1'b1}};
                neg_r <= {NUM_CH{1'b0}};
                ovf_r <= {NUM_CH{1'b0}};
            end else if (state_r == WRITE) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (sel_r == CH_W'(k + 1)) begin
                        seg_r[k*WR_W +: WR_W] <= wr_seg_s;
                        neg_r[k]              <= sign_r;
                        ovf_r[k]              <= wr_ovf_s;
                    end
                end
            end

            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        last_op_r <= op_s;
                        mag_r     <= mag_in_s;
                        sign_r    <= op_s[DATA_W-1];
                        sel_r     <= bus.display;
                        bcd_r     <= {BCD_W{1'b0}};
                        cnt_r     <= 5'd0;
                    end
                end
                CONVERT: begin
                    bcd_r <= bcd_step_s;
                    mag_r <= mag_step_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                default: cnt_r <= cnt_r;
            endcase

            busy_r <= (state_nxt_s != IDLE);
            done_r <= (state_r == WRITE) && !bus.clear;
        end
    end

    assign bus.seg  = seg_r;
    assign bus.neg  = neg_r;
    assign bus.ovf  = ovf_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_out_display_bank.sv
// Directed bench for out_display_bank with hand-computed 7-segment expectations.
module tb_out_display_bank;
    localparam int DATA_W = 16;
    localparam int NUM_CH = 3;
    localparam int DIGITS = 2;
    localparam int CH_W   = 16;
    localparam int SEG_W  = NUM_CH * DIGITS * 7;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] S9    = 7'b0010000;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic c = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   bcy;
    int   dcy;

    logic [SEG_W-1:0]  exp_seg;
    logic [NUM_CH-1:0] exp_neg;
    logic [NUM_CH-1:0] exp_ovf;

    always #5 c = ~c;

    out_display_bank_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIGITS(DIGITS), .CH_W(CH_W)) bus ();

    out_display_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIGITS(DIGITS), .CH_W(CH_W)) dut (
        .c     (c),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag);
        check({tag, " seg"}, 64'(bus.seg), 64'(exp_seg));
        check({tag, " neg"}, 64'(bus.neg), 64'(exp_neg));
        check({tag, " ovf"}, 64'(bus.ovf), 64'(exp_ovf));
    endtask

    task automatic set_ch(input int k, input logic [6:0] tens, input logic [6:0] ones);
        exp_seg[(k*DIGITS)*7 +: 7]     = ones;
        exp_seg[(k*DIGITS + 1)*7 +: 7] = tens;
    endtask

    task automatic blank_all();
        exp_seg = {SEG_W{1'b1}};
        exp_neg = {NUM_CH{1'b0}};
        exp_ovf = {NUM_CH{1'b0}};
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic start(input logic [1:0] src, input logic [CH_W-1:0] disp);
        bus.out_data_src = src;
        bus.display      = disp;
        bus.out          = 1'b1;
        tick();
        bus.out = 1'b0;
    endtask

    // Sample i is taken just after edge E_i; out/clear can be pulsed at a chosen sample
    task automatic watch(input int n, input int out_at, input int clr_at, output int b, output int d);
        b = 0;
        d = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.busy === 1'b1) b++;
            if (bus.done === 1'b1) d++;
            bus.out   = (i == out_at);
            bus.clear = (i == clr_at);
            tick();
        end
        bus.out   = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.out          = 1'b0;
        bus.out_data_src = 2'b00;
        bus.mem          = 16'h0000;
        bus.data_reg     = 16'h0000;
        bus.mem_reg      = 16'h0000;
        bus.display      = 16'd0;
        bus.clear        = 1'b0;
        blank_all();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check_disp("reset");
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle busy", 64'(bus.busy), 64'd0);
        end

        // 42 into channel 2
        bus.data_reg = 16'h002A;
        start(2'b10, 16'd2);
        watch(25, -1, -1, bcy, dcy);
        check("p42 busy cycles", 64'(bcy), 64'd17);
        check("p42 done count", 64'(dcy), 64'd1);
        set_ch(1, S4, S2);
        check_disp("p42");

        // -7 into channel 1
        bus.mem = 16'hFFF9;
        start(2'b01, 16'd1);
        watch(25, -1, -1, bcy, dcy);
        check("m7 done count", 64'(dcy), 64'd1);
        set_ch(0, S0, S7);
        exp_neg[0] = 1'b1;
        check_disp("m7");

        // most negative value overflows channel 3
        bus.mem_reg = 16'h8000;
        start(2'b11, 16'd3);
        watch(25, -1, -1, bcy, dcy);
        check("ovf done count", 64'(dcy), 64'd1);
        set_ch(2, DASH, DASH);
        exp_neg[2] = 1'b1;
        exp_ovf[2] = 1'b1;
        check_disp("ovf");

        // out while busy is ignored: channel 1 must keep -07
        bus.data_reg = 16'h0007;
        start(2'b10, 16'd2);
        bus.mem          = 16'h0005;
        bus.out_data_src = 2'b01;
        bus.display      = 16'd1;
        watch(25, 5, -1, bcy, dcy);
        check("busy-out busy cycles", 64'(bcy), 64'd17);
        check("busy-out done count", 64'(dcy), 64'd1);
        set_ch(1, S0, S7);
        exp_neg[1] = 1'b0;
        check_disp("busy-out");

        // clear mid-conversion
        bus.data_reg = 16'h002A;
        start(2'b10, 16'd2);
        watch(12, -1, 8, bcy, dcy);
        check("clear busy cycles", 64'(bcy), 64'd9);
        check("clear done count", 64'(dcy), 64'd0);
        check("clear busy after", 64'(bus.busy), 64'd0);
        blank_all();
        check_disp("clear");

        // reset mid-conversion after a channel holds a value
        start(2'b10, 16'd2);
        watch(25, -1, -1, bcy, dcy);
        set_ch(1, S4, S2);
        check_disp("pre-reset");
        bus.mem = 16'h0063;
        start(2'b01, 16'd1);
        watch(6, -1, -1, bcy, dcy);
        #2;
        reset = 1'b1;
        #1;
        blank_all();
        check_disp("async reset");
        check("async reset busy", 64'(bus.busy), 64'd0);
        check("async reset done", 64'(bus.done), 64'd0);
        @(posedge c);
        #1;
        reset = 1'b0;
        watch(20, -1, -1, bcy, dcy);
        check("post-reset busy cycles", 64'(bcy), 64'd0);
        check("post-reset done count", 64'(dcy), 64'd0);
        check_disp("post-reset");

        // reuse source right after reset uses a zero operand
        bus.mem      = 16'h0063;
        bus.data_reg = 16'h0063;
        bus.mem_reg  = 16'h0063;
        start(2'b00, 16'd3);
        watch(25, -1, -1, bcy, dcy);
        check("zero-op done count", 64'(dcy), 64'd1);
        set_ch(2, S0, S0);
        check_disp("zero-op");

        // load 99, then reuse it to an invalid channel and then to channel 1
        start(2'b10, 16'd2);
        watch(25, -1, -1, bcy, dcy);
        set_ch(1, S9, S9);
        check_disp("p99");
        bus.mem      = 16'h0011;
        bus.data_reg = 16'h0022;
        bus.mem_reg  = 16'h0033;
        start(2'b00, 16'd0);
        watch(25, -1, -1, bcy, dcy);
        check("disp0 busy cycles", 64'(bcy), 64'd17);
        check("disp0 done count", 64'(dcy), 64'd1);
        check_disp("disp0");
        start(2'b00, 16'd1);
        watch(25, -1, -1, bcy, dcy);
        check("reuse done count", 64'(dcy), 64'd1);
        set_ch(0, S9, S9);
        exp_neg[0] = 1'b0;
        check_disp("reuse");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
